// File: rtl/popcnt_pkg.sv
// Shared widths and helpers for the popcount arbiter slice.
package popcnt_pkg;

  localparam int TAG_WIDTH = 1;
  typedef logic [TAG_WIDTH-1:0] tag_t;

  function automatic int sum_width(input int vector_width);
    return $clog2(vector_width + 1);
  endfunction

  // Wide enough that FIFO_DEPTH - occupancy - in-flight + pop never aliases.
  function automatic int cred_width(input int depth, input int latency);
    return $clog2(depth + latency + 2);
  endfunction

endpackage

// File: rtl/bit_cntr.sv
// Pipelined population counter: per-granule counts, then a total, then the output register.
module bit_cntr #(
  parameter int VECTOR_WIDTH  = 50,
  parameter int GRANULE_WIDTH = 6,
  localparam int SUM_WIDTH    = $clog2(VECTOR_WIDTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [VECTOR_WIDTH-1:0] i_Vector,
  output logic [SUM_WIDTH-1:0]    o_Sum
);

  localparam int NUM_G  = (VECTOR_WIDTH + GRANULE_WIDTH - 1) / GRANULE_WIDTH;
  localparam int PAD_W  = NUM_G * GRANULE_WIDTH;
  localparam int GCNT_W = $clog2(GRANULE_WIDTH + 1);

  logic [PAD_W-1:0]     vec_pad_s;
  logic [GCNT_W-1:0]    gcnt_d [NUM_G];
  logic [GCNT_W-1:0]    gcnt_q [NUM_G];
  logic [SUM_WIDTH-1:0] total_d;
  logic [SUM_WIDTH-1:0] total_q;
  logic [SUM_WIDTH-1:0] sum_q;

  assign vec_pad_s = PAD_W'(i_Vector);

  always_comb begin
    for (int g = 0; g < NUM_G; g++) begin
      gcnt_d[g] = '0;
      for (int b = 0; b < GRANULE_WIDTH; b++) begin
        gcnt_d[g] = gcnt_d[g] + GCNT_W'(vec_pad_s[g*GRANULE_WIDTH + b]);
      end
    end
  end

  always_comb begin
    total_d = '0;
    for (int g = 0; g < NUM_G; g++) begin
      total_d = total_d + SUM_WIDTH'(gcnt_q[g]);
    end
  end

  // Three register stages give the fixed three-cycle latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < NUM_G; g++) begin
        gcnt_q[g] <= '0;
      end
      total_q <= '0;
      sum_q   <= '0;
    end else begin
      for (int g = 0; g < NUM_G; g++) begin
        gcnt_q[g] <= gcnt_d[g];
      end
      total_q <= total_d;
      sum_q   <= total_q;
    end
  end

  assign o_Sum = sum_q;

endmodule

// File: rtl/popcnt_fifo.sv
// First-word-fall-through result buffer with wrapping pointers and an occupancy counter.
module popcnt_fifo #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 7,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_Push,
  input  logic [DATA_WIDTH-1:0] i_Data,
  input  logic                  i_Pop,
  output logic [DATA_WIDTH-1:0] o_Data,
  output logic                  o_Empty,
  output logic [CNT_W-1:0]      o_Count
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  pop_s;

  assign pop_s = i_Pop & (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_Push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({i_Push, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (i_Push) begin
        mem_q[wr_ptr_q] <= i_Data;
      end
    end
  end

  assign o_Data  = mem_q[rd_ptr_q];
  assign o_Empty = (count_q == '0);
  assign o_Count = count_q;

endmodule

// File: rtl/popcnt_arbiter.sv
// Two-requester round-robin front end to a pipelined bit counter, with a
// credit-limited in-order result FIFO.
module popcnt_arbiter
  import popcnt_pkg::*;
#(
  parameter int VECTOR_WIDTH  = 50,
  parameter int GRANULE_WIDTH = 6,
  parameter int CNT_LATENCY   = 3,
  parameter int FIFO_DEPTH    = 4,
  localparam int SUM_WIDTH    = sum_width(VECTOR_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [VECTOR_WIDTH-1:0] i_Req0_Vector,
  input  logic                    i_Req0_Valid,
  output logic                    o_Req0_Ready,
  input  logic [VECTOR_WIDTH-1:0] i_Req1_Vector,
  input  logic                    i_Req1_Valid,
  output logic                    o_Req1_Ready,
  output logic [SUM_WIDTH-1:0]    o_Sum,
  output logic                    o_Tag,
  output logic                    o_Valid,
  input  logic                    i_Ready
);

  localparam int CRED_WIDTH = cred_width(FIFO_DEPTH, CNT_LATENCY);
  localparam int FLIGHT_W   = $clog2(CNT_LATENCY + 1);
  localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W    = TAG_WIDTH + SUM_WIDTH;

  logic                    prio_q, prio_d;
  logic [CNT_LATENCY-1:0]  vld_q, vld_d;
  tag_t                    tag_q [CNT_LATENCY];
  tag_t                    tag_d [CNT_LATENCY];
  logic [FLIGHT_W-1:0]     inflight_s;
  logic [CRED_WIDTH-1:0]   credits_s;
  logic                    issue_ok_s, gnt0_s, gnt1_s, pop_s, fifo_empty_s;
  logic [VECTOR_WIDTH-1:0] cnt_in_s;
  logic [SUM_WIDTH-1:0]    cnt_sum_s;
  logic [OCC_W-1:0]        occ_s;
  logic [ENTRY_W-1:0]      fifo_head_s;

  always_comb begin
    inflight_s = '0;
    for (int i = 0; i < CNT_LATENCY; i++) begin
      inflight_s = inflight_s + FLIGHT_W'(vld_q[i]);
    end
  end

  // A pop this cycle frees a slot at the same edge, which keeps full throughput.
  assign pop_s      = ~rst & ~fifo_empty_s & i_Ready;
  assign credits_s  = CRED_WIDTH'(FIFO_DEPTH) - CRED_WIDTH'(occ_s)
                    - CRED_WIDTH'(inflight_s) + CRED_WIDTH'(pop_s);
  assign issue_ok_s = ~rst & (credits_s != '0);
  assign gnt0_s     = issue_ok_s & i_Req0_Valid & (~i_Req1_Valid | ~prio_q);
  assign gnt1_s     = issue_ok_s & i_Req1_Valid & (~i_Req0_Valid | prio_q);
  assign o_Req0_Ready = gnt0_s;
  assign o_Req1_Ready = gnt1_s;

  always_comb begin
    cnt_in_s = '0;
    prio_d   = prio_q;
    if (gnt0_s) begin
      cnt_in_s = i_Req0_Vector;
      prio_d   = 1'b1;
    end else if (gnt1_s) begin
      cnt_in_s = i_Req1_Vector;
      prio_d   = 1'b0;
    end else begin
      cnt_in_s = '0;
      prio_d   = prio_q;
    end
    vld_d    = {vld_q[CNT_LATENCY-2:0], gnt0_s | gnt1_s};
    tag_d[0] = gnt1_s ? tag_t'(1'b1) : tag_t'(1'b0);
    for (int i = 1; i < CNT_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
      vld_q  <= '0;
      for (int i = 0; i < CNT_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      prio_q <= prio_d;
      vld_q  <= vld_d;
      for (int i = 0; i < CNT_LATENCY; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  bit_cntr #(
    .VECTOR_WIDTH  (VECTOR_WIDTH),
    .GRANULE_WIDTH (GRANULE_WIDTH)
  ) u_bit_cntr (
    .clk      (clk),
    .rst_n    (~rst),
    .i_Vector (cnt_in_s),
    .o_Sum    (cnt_sum_s)
  );

  popcnt_fifo #(
    .DEPTH      (FIFO_DEPTH),
    .DATA_WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_Push  (vld_q[CNT_LATENCY-1]),
    .i_Data  ({tag_q[CNT_LATENCY-1], cnt_sum_s}),
    .i_Pop   (pop_s),
    .o_Data  (fifo_head_s),
    .o_Empty (fifo_empty_s),
    .o_Count (occ_s)
  );

  assign o_Valid = ~rst & ~fifo_empty_s;
  assign o_Sum   = o_Valid ? fifo_head_s[SUM_WIDTH-1:0] : '0;
  assign o_Tag   = o_Valid ? fifo_head_s[ENTRY_W-1] : 1'b0;

endmodule

// File: tb/tb_popcnt_arbiter.sv
// Directed bench for popcnt_arbiter: hand-computed sums, a queue of expected results in issue order.
module tb_popcnt_arbiter;

  localparam int VW = 50;
  localparam int SW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [VW-1:0] i_Req0_Vector, i_Req1_Vector;
  logic          i_Req0_Valid, i_Req1_Valid;
  logic          o_Req0_Ready, o_Req1_Ready;
  logic [SW-1:0] o_Sum;
  logic          o_Tag, o_Valid, i_Ready;

  int            n_checks = 0;
  int            n_fails  = 0;
  int            acc;
  logic [SW:0]   exp_q [$];
  logic [SW-1:0] sum0_exp, sum1_exp;
  logic [VW-1:0] vecs [3];
  logic [SW-1:0] sums [3];

  popcnt_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .i_Req0_Vector (i_Req0_Vector),
    .i_Req0_Valid  (i_Req0_Valid),
    .o_Req0_Ready  (o_Req0_Ready),
    .i_Req1_Vector (i_Req1_Vector),
    .i_Req1_Valid  (i_Req1_Valid),
    .o_Req1_Ready  (o_Req1_Ready),
    .o_Sum         (o_Sum),
    .o_Tag         (o_Tag),
    .o_Valid       (o_Valid),
    .i_Ready       (i_Ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Score the head result if popped, log accepts, then advance one clock.
  task automatic tick();
    logic [SW:0] e;
    #1;
    if (o_Valid && i_Ready) begin
      if (exp_q.size() == 0) begin
        check_eq("stray_result", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq("order_sum", o_Sum, e[SW-1:0]);
        check_eq("order_tag", o_Tag, e[SW]);
      end
    end
    if (i_Req0_Valid && o_Req0_Ready) exp_q.push_back({1'b0, sum0_exp});
    if (i_Req1_Valid && o_Req1_Ready) exp_q.push_back({1'b1, sum1_exp});
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    i_Ready = 1'b1;
    for (int c = 0; c < budget && exp_q.size() != 0; c++) begin
      tick();
    end
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    check_eq("drain_idle", o_Valid, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    i_Req0_Vector = '1;
    i_Req1_Vector = '1;
    i_Req0_Valid = 1'b1;
    i_Req1_Valid = 1'b1;
    i_Ready = 1'b1;
    sum0_exp = 6'd0;
    sum1_exp = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", o_Valid, 64'd0);
    check_eq("rst_ready0", o_Req0_Ready, 64'd0);
    check_eq("rst_ready1", o_Req1_Ready, 64'd0);
    check_eq("rst_sum", o_Sum, 64'd0);
    check_eq("rst_tag", o_Tag, 64'd0);
    rst = 1'b0;
    i_Req0_Valid = 1'b0;
    i_Req1_Valid = 1'b0;
    tick();

    // All ones from requester 0: three-cycle latency, sum 50.
    i_Req0_Vector = 50'h3FFFFFFFFFFFF;
    sum0_exp = 6'd50;
    i_Req0_Valid = 1'b1;
    #1;
    check_eq("t1_ready0", o_Req0_Ready, 64'd1);
    tick();
    i_Req0_Valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_eq("t1_early_valid", o_Valid, 64'd0);
      tick();
    end
    check_eq("t1_valid", o_Valid, 64'd1);
    check_eq("t1_sum", o_Sum, 64'd50);
    check_eq("t1_tag", o_Tag, 64'd0);
    tick();
    check_eq("t1_popped", o_Valid, 64'd0);

    // Requester 1 back to back: 24, 24, 12 on consecutive cycles.
    vecs[0] = 50'h0F0F0F0F0F0F0; sums[0] = 6'd24;
    vecs[1] = 50'h0666666666666; sums[1] = 6'd24;
    vecs[2] = 50'h0111111111111; sums[2] = 6'd12;
    i_Req1_Valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_Req1_Vector = vecs[i];
      sum1_exp = sums[i];
      #1;
      check_eq("t2_ready1", o_Req1_Ready, 64'd1);
      tick();
    end
    i_Req1_Valid = 1'b0;
    check_eq("t2_early_valid", o_Valid, 64'd0);
    for (int j = 0; j < 3; j++) begin
      tick();
      check_eq("t2_valid", o_Valid, 64'd1);
      check_eq("t2_sum", o_Sum, 64'(sums[j]));
      check_eq("t2_tag", o_Tag, 64'd1);
    end
    tick();
    check_eq("t2_idle", o_Valid, 64'd0);

    // All-zero vector still produces a valid result of 0.
    i_Req0_Vector = '0;
    sum0_exp = 6'd0;
    i_Req0_Valid = 1'b1;
    #1;
    check_eq("t3_ready0", o_Req0_Ready, 64'd1);
    tick();
    i_Req0_Valid = 1'b0;
    repeat (2) tick();
    check_eq("t3_early_valid", o_Valid, 64'd0);
    tick();
    check_eq("t3_valid", o_Valid, 64'd1);
    check_eq("t3_sum", o_Sum, 64'd0);
    tick();

    // Fresh reset, then both requesters streaming: strict alternation from 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    i_Req0_Vector = 50'h1; sum0_exp = 6'd1;
    i_Req1_Vector = 50'h3; sum1_exp = 6'd2;
    i_Req0_Valid = 1'b1;
    i_Req1_Valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check_eq("t4_ready0", o_Req0_Ready, 64'(i % 2 == 0));
      check_eq("t4_ready1", o_Req1_Ready, 64'(i % 2 == 1));
      if (i >= 4) begin
        check_eq("t4_stream_valid", o_Valid, 64'd1);
        check_eq("t4_stream_tag", o_Tag, 64'(i % 2));
      end
      tick();
    end
    i_Req0_Valid = 1'b0;
    i_Req1_Valid = 1'b0;
    drain(20);

    // Consumer stalled: exactly four accepts, then drain in order.
    i_Ready = 1'b0;
    i_Req0_Valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      i_Req0_Vector = (50'd1 << (i + 1)) - 50'd1;
      sum0_exp = SW'(i + 1);
      #1;
      check_eq("t5_ready0", o_Req0_Ready, 64'(i < 4));
      if (o_Req0_Ready) acc++;
      tick();
    end
    check_eq("t5_accepts", 64'(acc), 64'd4);
    i_Req0_Valid = 1'b0;
    drain(30);

    // Reset with results both buffered and in flight: nothing survives.
    i_Ready = 1'b0;
    i_Req0_Valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      i_Req0_Vector = (50'd1 << (i + 10)) - 50'd1;
      sum0_exp = SW'(i + 10);
      tick();
    end
    check_eq("t6_pre_valid", o_Valid, 64'd1);
    rst = 1'b1;
    #1;
    check_eq("t6_rst_valid", o_Valid, 64'd0);
    check_eq("t6_rst_ready0", o_Req0_Ready, 64'd0);
    tick();
    rst = 1'b0;
    i_Req0_Valid = 1'b0;
    exp_q.delete();
    #1;
    check_eq("t6_post_valid", o_Valid, 64'd0);
    i_Ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("t6_no_stale", o_Valid, 64'd0);
    end
    i_Req0_Vector = 50'h5;
    sum0_exp = 6'd2;
    i_Req0_Valid = 1'b1;
    #1;
    check_eq("t6_ready0", o_Req0_Ready, 64'd1);
    tick();
    i_Req0_Valid = 1'b0;
    drain(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
